// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward S-box, round constants, key-expand state encoding.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic {StIdle, StExpand} ke_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by the 4-bit round counter; unused slots are zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_o[8*i +: 8] = sbox_lookup(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: one round key per clock after a Command rising edge.
// Optional KEY_CACHE_EN skips re-expansion when restarted with the already-expanded key.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Command,
  input  logic [127:0] Key,
  output logic [127:0] Round1,
  output logic [127:0] Round2,
  output logic [127:0] Round3,
  output logic [127:0] Round4,
  output logic [127:0] Round5,
  output logic [127:0] Round6,
  output logic [127:0] Round7,
  output logic [127:0] Round8,
  output logic [127:0] Round9,
  output logic [127:0] Round10,
  output logic         Busy,
  output logic         Complete_Flag
);

  ke_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_cmd_q;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  aes_block_t key_q, key_d;
  aes_block_t round_q [1:10];
  aes_block_t round_d [1:10];

  logic       start;
  logic       cache_hit;
  aes_block_t prev;
  aes_block_t next_round;
  logic [31:0] sub_out;
  logic [31:0] t;

  assign start = Command & ~last_cmd_q;

`ifdef KEY_CACHE_EN
  assign cache_hit = done_q && (Key == key_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Round i derives from Round(i-1), except Round1 which derives from the captured key.
  always_comb begin
    prev = key_q;
    for (int i = 1; i <= 9; i++) begin
      if (cnt_q == 4'(i + 1)) prev = round_q[i];
    end
  end

  aes_sub_word u_sub_word (
    .word_i ({prev[23:0], prev[31:24]}),
    .word_o (sub_out)
  );

  assign t = sub_out ^ {RCON[cnt_q], 24'h0};

  always_comb begin
    next_round[127:96] = prev[127:96] ^ t;
    next_round[95:64]  = prev[95:64] ^ next_round[127:96];
    next_round[63:32]  = prev[63:32] ^ next_round[95:64];
    next_round[31:0]   = prev[31:0] ^ next_round[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    key_d   = key_q;
    round_d = round_q;
    unique case (state_q)
      StIdle: begin
        if (start && !cache_hit) begin
          key_d   = Key;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = StExpand;
        end
      end
      StExpand: begin
        for (int i = 1; i <= 10; i++) begin
          if (cnt_q == 4'(i)) round_d[i] = next_round;
        end
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      last_cmd_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      key_q      <= '0;
      for (int i = 1; i <= 10; i++) round_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_cmd_q <= Command;
      busy_q     <= busy_d;
      done_q     <= done_d;
      key_q      <= key_d;
      for (int i = 1; i <= 10; i++) round_q[i] <= round_d[i];
    end
  end

  assign Round1        = round_q[1];
  assign Round2        = round_q[2];
  assign Round3        = round_q[3];
  assign Round4        = round_q[4];
  assign Round5        = round_q[5];
  assign Round6        = round_q[6];
  assign Round7        = round_q[7];
  assign Round8        = round_q[8];
  assign Round9        = round_q[9];
  assign Round10       = round_q[10];
  assign Busy          = busy_q;
  assign Complete_Flag = done_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128: independent key-schedule model feeding a scoreboard.
module tb_aes_key_expand_128;

  typedef logic [9:0][127:0] rk_t;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] r1, r2, r3, r4, r5, r6, r7, r8, r9, r10;
  logic         busy, done;
  rk_t          obs;

  int  checks = 0;
  int  errors = 0;
  rk_t sb_q[$];
  logic [7:0] sbox_ref [256];

  always #5 clk = ~clk;

  assign obs = {r10, r9, r8, r7, r6, r5, r4, r3, r2, r1};

  aes_key_expand_128 dut (
    .Clock         (clk),
    .Reset_n       (rst_n),
    .Command       (cmd),
    .Key           (key),
    .Round1        (r1),
    .Round2        (r2),
    .Round3        (r3),
    .Round4        (r4),
    .Round5        (r5),
    .Round6        (r6),
    .Round7        (r7),
    .Round8        (r8),
    .Round9        (r9),
    .Round10       (r10),
    .Busy          (busy),
    .Complete_Flag (done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus affine transform, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_ref[x] = s;
    end
  endtask

  function automatic rk_t ref_expand(input logic [127:0] k);
    rk_t rk;
    logic [127:0] prev = k;
    logic [31:0] w3, t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 10; i++) begin
      w3 = prev[31:0];
      t = {sbox_ref[w3[23:16]], sbox_ref[w3[15:8]], sbox_ref[w3[7:0]], sbox_ref[w3[31:24]]}
          ^ {rc, 24'h0};
      rk[i][127:96] = prev[127:96] ^ t;
      rk[i][95:64]  = prev[95:64] ^ rk[i][127:96];
      rk[i][63:32]  = prev[63:32] ^ rk[i][95:64];
      rk[i][31:0]   = prev[31:0] ^ rk[i][63:32];
      prev = rk[i];
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
    return rk;
  endfunction

  // Drops Command for one sample, then raises it with the new key; returns just before edge T.
  task automatic do_start(input logic [127:0] k, input bit expect_run);
    @(negedge clk);
    cmd = 1'b0;
    @(negedge clk);
    cmd = 1'b1;
    key = k;
    if (expect_run) sb_q.push_back(ref_expand(k));
  endtask

  // k counts negedges after the start edge T (k=0 is just after T); lat=-1 on timeout.
  task automatic wait_complete(input int k0, output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int k = k0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b, expected 0 0", busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== '0) begin
        errors++;
        $display("FAIL reset_round%0d: got %h expected 0", i + 1, obs[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    rk_t exp;
    int lat, busy_n;
    do_start(FipsKey, 1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL fips_start: busy=%b done=%b, expected 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (r1 !== FipsR1) begin
      errors++;
      $display("FAIL fips_round1_at_t1: got %h expected %h", r1, FipsR1);
    end
    wait_complete(2, lat, busy_n);
    checks++;
    if (lat !== 10 || busy_n !== 8) begin
      errors++;
      $display("FAIL fips_latency: lat=%0d busy_rest=%0d, expected 10 8", lat, busy_n);
    end
    checks++;
    if (r10 !== FipsR10) begin
      errors++;
      $display("FAIL fips_round10: got %h expected %h", r10, FipsR10);
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL fips_sb_round%0d: got %h expected %h", i + 1, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_zero_key();
    rk_t exp;
    int lat, busy_n;
    do_start('0, 1'b1);
    wait_complete(0, lat, busy_n);
    checks++;
    if (lat !== 10 || busy_n !== 10) begin
      errors++;
      $display("FAIL zero_busy: lat=%0d busy_cycles=%0d, expected 10 10", lat, busy_n);
    end
    checks++;
    if (r1 !== ZeroR1 || r10 !== ZeroR10) begin
      errors++;
      $display("FAIL zero_vectors: r1=%h r10=%h, expected %h %h", r1, r10, ZeroR1, ZeroR10);
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL zero_sb_round%0d: got %h expected %h", i + 1, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_ignore_during_expand();
    int lat, busy_n;
    do_start(FipsKey, 1'b1);
    repeat (3) @(negedge clk);
    key = ~FipsKey;
    cmd = 1'b0;
    @(negedge clk);
    cmd = 1'b1;
    wait_complete(4, lat, busy_n);
    checks++;
    if (lat !== 10 || r1 !== FipsR1 || r10 !== FipsR10) begin
      errors++;
      $display("FAIL ignore_changes: lat=%0d r1=%h r10=%h, expected 10 %h %h",
               lat, r1, r10, FipsR1, FipsR10);
    end
    void'(sb_q.pop_front());
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_not_queued: busy=%b done=%b, expected 0 1", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    rk_t exp;
    int lat, busy_n;
    do_start(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    cmd = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_status: busy=%b done=%b, expected 0 0", busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== '0) begin
        errors++;
        $display("FAIL midreset_round%0d: got %h expected 0", i + 1, obs[i]);
      end
    end
    void'(sb_q.pop_front());
    rst_n = 1'b1;
    do_start(FipsKey, 1'b1);
    wait_complete(0, lat, busy_n);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL midreset_restart_latency: got %0d expected 10", lat);
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL midreset_sb_round%0d: got %h expected %h", i + 1, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_held_high();
    rk_t exp;
    int lat, busy_n;
    logic [127:0] k2 = 128'h3243f6a8885a308d313198a2e0370734;
    busy_n = 0;
    do_start(128'hffeeddccbbaa99887766554433221100, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    checks++;
    if (busy_n !== 10 || done !== 1'b1) begin
      errors++;
      $display("FAIL held_single_run: busy_cycles=%0d done=%b, expected 10 1", busy_n, done);
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL held_sb_round%0d: got %h expected %h", i + 1, obs[i], exp[i]);
      end
    end
    // Command stays high through reset: first post-reset sample is a start edge.
    key = k2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back(ref_expand(k2));
    rst_n = 1'b1;
    wait_complete(0, lat, busy_n);
    checks++;
    if (lat !== 10 || busy_n !== 10) begin
      errors++;
      $display("FAIL held_across_reset: lat=%0d busy_cycles=%0d, expected 10 10", lat, busy_n);
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL held_reset_sb_round%0d: got %h expected %h", i + 1, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_restart_same_key();
    rk_t exp;
    int lat, busy_n;
    logic [127:0] k2 = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef KEY_CACHE_EN
    int done_low;
    done_low = 0;
    busy_n = 0;
    do_start(k2, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (!done) done_low++;
    end
    checks++;
    if (busy_n !== 0 || done_low !== 0) begin
      errors++;
      $display("FAIL cache_hit: busy_cycles=%0d flag_low_cycles=%0d, expected 0 0",
               busy_n, done_low);
    end
    do_start(~k2, 1'b1);
`else
    do_start(k2, 1'b1);
`endif
    wait_complete(0, lat, busy_n);
    checks++;
    if (lat !== 10 || busy_n !== 10) begin
      errors++;
      $display("FAIL restart_full_run: lat=%0d busy_cycles=%0d, expected 10 10", lat, busy_n);
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL restart_sb_round%0d: got %h expected %h", i + 1, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rk_t exp;
    int lat, busy_n;
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k, 1'b1);
      wait_complete(0, lat, busy_n);
      checks++;
      if (lat !== 10) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d expected 10", n, lat);
      end
      exp = sb_q.pop_front();
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs[i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b[%0d]_round%0d: got %h expected %h", n, i + 1, obs[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_ignore_during_expand();
    test_reset_mid();
    test_held_high();
    test_restart_same_key();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
